// File: rtl/sevenseg_pkg.sv
// Shared constants for the 7-segment display driver: blank/dash patterns,
// conversion FSM states and the active-low hex segment table (bit0 = a .. bit6 = g).
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Index 0 is the leftmost entry; each entry is written g..a, 0 = segment lit
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/sevenseg_hex_decode.sv
// Combinational nibble-to-segment decoder covering the full 0-F range.
module sevenseg_hex_decode
    import sevenseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = seg_of(nibble);

endmodule

// File: rtl/sevenseg_bin_display.sv
// Multi-digit 7-segment driver: binary to decimal (double-dabble) or hex, with
// overflow dashes and blink. Optional macro: SEVENSEG_LEADING_ZERO_BLANK_EN.
module sevenseg_bin_display
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BIN_WIDTH  = 14,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [BIN_WIDTH-1:0]    bin_value,
    input  logic                    hex_mode,
    input  logic                    blink_en,
    output logic                    busy,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex_segs
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int EXT_W = (BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W;
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    state_t                    state;
    state_t                    state_nx;
    logic [BIN_WIDTH-1:0]      bin_r;
    logic                      hex_r;
    logic [BCD_W-1:0]          bcd;
    logic [BCD_W-1:0]          bcd_adj;
    logic [CNT_W-1:0]          shift_cnt;
    logic                      ovf_int;
    logic [7*NUM_DIGITS-1:0]   seg_r;
    logic                      ovf_r;
    logic [BLK_W-1:0]          blink_cnt;
    logic                      blink_off;

    logic [EXT_W-1:0]          bin_ext;
    logic                      hex_ovf;
    logic [BCD_W-1:0]          digit_src;
    logic                      res_ovf;
    logic [7*NUM_DIGITS-1:0]   dec_segs;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [7*NUM_DIGITS-1:0]   disp_next;

    // FSM: state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = hex_mode ? DONE : SHIFT;
            SHIFT:   if (shift_cnt == CNT_W'(1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Add-3 correction on every BCD nibble that is 5 or more
    always_comb begin
        bcd_adj = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
    end

    // Conversion datapath
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            bin_r     <= '0;
            hex_r     <= 1'b0;
            bcd       <= '0;
            shift_cnt <= '0;
            ovf_int   <= 1'b0;
            seg_r     <= {NUM_DIGITS{SEG_BLANK}};
            ovf_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_r     <= bin_value;
                        hex_r     <= hex_mode;
                        bcd       <= '0;
                        ovf_int   <= 1'b0;
                        shift_cnt <= CNT_W'(BIN_WIDTH);
                    end
                end
                SHIFT: begin
                    bcd       <= {bcd_adj[BCD_W-2:0], bin_r[BIN_WIDTH-1]};
                    bin_r     <= bin_r << 1;
                    shift_cnt <= shift_cnt - CNT_W'(1);
                    if (bcd_adj[BCD_W-1]) begin
                        ovf_int <= 1'b1;
                    end
                end
                DONE: begin
                    seg_r <= disp_next;
                    ovf_r <= res_ovf;
                end
                default: ;
            endcase
        end
    end

    // Hex mode keeps bin_r unshifted, so it can be read directly in DONE
    assign bin_ext   = EXT_W'(bin_r);
    assign hex_ovf   = |(bin_ext >> BCD_W);
    assign digit_src = hex_r ? bin_ext[BCD_W-1:0] : bcd;
    assign res_ovf   = hex_r ? hex_ovf : ovf_int;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        sevenseg_hex_decode u_dec (
            .nibble (digit_src[4*g +: 4]),
            .segs   (dec_segs[7*g +: 7])
        );
    end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    // Blank zeros above the most significant nonzero digit; digit 0 always shows
    always_comb begin
        logic lead;
        int unsigned k;
        blank_mask = '0;
        lead       = 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            k = NUM_DIGITS - 1 - i;
            if (lead && (digit_src[4*k +: 4] == 4'd0) && (k != 0)) begin
                blank_mask[k] = 1'b1;
            end
            if (digit_src[4*k +: 4] != 4'd0) begin
                lead = 1'b0;
            end
        end
    end
`else
    assign blank_mask = '0;
`endif

    always_comb begin
        disp_next = '0;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (res_ovf) begin
                disp_next[7*d +: 7] = SEG_DASH;
            end else if (blank_mask[d]) begin
                disp_next[7*d +: 7] = SEG_BLANK;
            end else begin
                disp_next[7*d +: 7] = dec_segs[7*d +: 7];
            end
        end
    end

    // Blink phase register doubles as the output mask
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (!blink_en) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + BLK_W'(1);
        end
    end

    assign busy     = (state != IDLE);
    assign overflow = ovf_r;
    assign hex_segs = blink_off ? '1 : seg_r;

endmodule
